// File: rtl/fetch_sequencer.sv
// Fetch-control FSM: issues instruction reads at the PC, hands instructions to decode, steps/redirects the PC.
// Optional FETCH_TIMEOUT_EN adds a fetch-wait watchdog that sets the sticky fetch_error flag.
module fetch_sequencer #(
    parameter int unsigned I_ADDR_W = 12,
    parameter int unsigned INSTR_W  = 16,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [I_ADDR_W-1:0] pc,
    output logic                pc_enable,
    output logic                jump_branch_select,
    output logic                immediate_select,
    output logic                unconditional_branch,
    output logic [2:0]          branch_condition,
    output logic [I_ADDR_W-1:0] address_immediate,
    output logic                imem_req,
    output logic [I_ADDR_W-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic                instr_valid,
    output logic [INSTR_W-1:0]  instr,
    output logic [I_ADDR_W-1:0] instr_pc,
    input  logic                instr_ready,
    input  logic                redirect_valid,
    output logic                redirect_ready,
    input  logic                redirect_imm_sel,
    input  logic                redirect_uncond,
    input  logic [2:0]          redirect_cond,
    input  logic [I_ADDR_W-1:0] redirect_addr,
    input  logic                halt,
    output logic                fetch_error
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FETCH    = 2'd1,
        S_HOLD     = 2'd2,
        S_REDIRECT = 2'd3
    } state_e;

    state_e                state_q;
    logic [INSTR_W-1:0]    instr_q;
    logic [I_ADDR_W-1:0]   instr_pc_q;
    logic [I_ADDR_W-1:0]   redir_addr_q;
    logic                  redir_imm_q;
    logic                  redir_uncond_q;
    logic [2:0]            redir_cond_q;

    logic in_fetch;
    logic in_hold;
    logic in_redir;
    logic redir_acc;
    logic fetch_done;
    logic timeout_hit;
    logic stuck;

    assign in_fetch   = (state_q == S_FETCH);
    assign in_hold    = (state_q == S_HOLD);
    assign in_redir   = (state_q == S_REDIRECT);
    assign redirect_ready = in_fetch | in_hold;
    assign redir_acc  = redirect_valid & redirect_ready;
    // An accepted redirect squashes a same-cycle ack so the PC never double-steps.
    assign fetch_done = in_fetch & imem_ack & ~redirect_valid;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt_q;
    logic             err_q;

    assign timeout_hit = in_fetch & ~imem_ack & ~redirect_valid
                       & (wait_cnt_q == CNT_W'(TIMEOUT - 1));

    // Counts unacknowledged FETCH cycles; zero whenever outside FETCH so each entry starts fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (!in_fetch || imem_ack || redirect_valid) begin
                wait_cnt_q <= '0;
            end else begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign fetch_error = err_q;
    assign stuck       = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 32'd0);
    assign timeout_hit    = 1'b0;
    assign stuck          = 1'b0;
    assign fetch_error    = 1'b0;
`endif

    // Sequencing FSM plus captured instruction and redirect request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            instr_q        <= '0;
            instr_pc_q     <= '0;
            redir_addr_q   <= '0;
            redir_imm_q    <= 1'b0;
            redir_uncond_q <= 1'b0;
            redir_cond_q   <= 3'd0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (!halt && !stuck) begin
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (redir_acc) begin
                        state_q <= S_REDIRECT;
                    end else if (imem_ack) begin
                        instr_q    <= imem_rdata;
                        instr_pc_q <= pc;
                        state_q    <= S_HOLD;
                    end else if (timeout_hit) begin
                        state_q <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (redir_acc) begin
                        state_q <= S_REDIRECT;
                    end else if (instr_ready) begin
                        if (halt) begin
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_REDIRECT: begin
                    state_q <= S_FETCH;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
            if (redir_acc) begin
                redir_addr_q   <= redirect_addr;
                redir_imm_q    <= redirect_imm_sel;
                redir_uncond_q <= redirect_uncond;
                redir_cond_q   <= redirect_cond;
            end
        end
    end

    assign pc_enable            = fetch_done | in_redir;
    assign jump_branch_select   = in_redir;
    assign immediate_select     = in_redir & redir_imm_q;
    assign unconditional_branch = in_redir & redir_uncond_q;
    assign branch_condition     = in_redir ? redir_cond_q : 3'd0;
    assign address_immediate    = in_redir ? redir_addr_q : '0;
    assign imem_req             = in_fetch;
    assign imem_addr            = in_fetch ? pc : '0;
    assign instr_valid          = in_hold;
    assign instr                = instr_q;
    assign instr_pc             = instr_pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: PC and memory stubs, transaction-level model, directed cycle table.
module tb_fetch_sequencer;

    localparam int unsigned AW = 12;
    localparam int unsigned IW = 16;
    localparam int unsigned TO = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] pc;
    logic          pc_enable, jump_branch_select, immediate_select, unconditional_branch;
    logic [2:0]    branch_condition;
    logic [AW-1:0] address_immediate;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [IW-1:0] imem_rdata;
    logic          instr_valid;
    logic [IW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_ready;
    logic          redirect_valid, redirect_ready, redirect_imm_sel, redirect_uncond;
    logic [2:0]    redirect_cond;
    logic [AW-1:0] redirect_addr;
    logic          halt;
    logic          fetch_error;

    logic          zero_flag;
    logic          ack_en;
    int unsigned   ack_wait;
    int unsigned   wcnt = 0;
    int            cyc = -1;
    int            checks = 0;
    int            errors = 0;

    fetch_sequencer #(.I_ADDR_W(AW), .INSTR_W(IW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc),
        .pc_enable(pc_enable), .jump_branch_select(jump_branch_select),
        .immediate_select(immediate_select), .unconditional_branch(unconditional_branch),
        .branch_condition(branch_condition), .address_immediate(address_immediate),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
        .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
        .redirect_imm_sel(redirect_imm_sel), .redirect_uncond(redirect_uncond),
        .redirect_cond(redirect_cond), .redirect_addr(redirect_addr),
        .halt(halt), .fetch_error(fetch_error)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        return 16'hA000 | IW'(a);
    endfunction

    // Condition 1 = branch if zero, 2 = branch if not zero.
    function automatic logic taken(input logic unc, input logic [2:0] cond, input logic z);
        return unc || (cond == 3'd1 && z) || (cond == 3'd2 && !z);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // program_counter stub
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (pc_enable) begin
            if (jump_branch_select && taken(unconditional_branch, branch_condition, zero_flag))
                pc <= immediate_select ? address_immediate : pc + address_immediate;
            else
                pc <= pc + 1'b1;
        end
    end

    // Instruction memory stub: ack after ack_wait unacknowledged request cycles.
    assign imem_ack   = ack_en && imem_req && (wcnt >= ack_wait);
    assign imem_rdata = mem_word(imem_addr);
    always @(posedge clk) begin
        if (imem_req && !imem_ack) wcnt <= wcnt + 1;
        else                       wcnt <= 0;
    end

    // Transaction-level model: PC evolves by completed fetches and accepted redirects.
    logic [AW-1:0] m_pc, m_ipc, m_raddr;
    logic          m_pend, m_runc, m_rimm, m_err;
    logic [2:0]    m_rcond;
    int            m_wait;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_pc = '0; m_ipc = '0; m_raddr = '0; m_pend = 1'b0; m_runc = 1'b0;
            m_rimm = 1'b0; m_err = 1'b0; m_rcond = 3'd0; m_wait = 0;
        end else begin
            chk("m_pc", 32'(pc), 32'(m_pc));
            chk("m_imem_addr", 32'(imem_addr), imem_req ? 32'(m_pc) : 32'd0);
            chk("m_redirect_ready", 32'(redirect_ready), 32'(imem_req | instr_valid));
            chk("m_req_vs_valid", 32'(imem_req & instr_valid), 32'd0);
            if (instr_valid) begin
                chk("m_instr", 32'(instr), 32'(mem_word(m_ipc)));
                chk("m_instr_pc", 32'(instr_pc), 32'(m_ipc));
            end
            chk("m_pc_enable", 32'(pc_enable), 32'((imem_req && imem_ack && !redirect_valid) || m_pend));
            chk("m_jbs", 32'(jump_branch_select), 32'(m_pend));
            chk("m_imm_sel", 32'(immediate_select), 32'(m_pend & m_rimm));
            chk("m_uncond", 32'(unconditional_branch), 32'(m_pend & m_runc));
            chk("m_cond", 32'(branch_condition), m_pend ? 32'(m_rcond) : 32'd0);
            chk("m_addr_imm", 32'(address_immediate), m_pend ? 32'(m_raddr) : 32'd0);
            chk("m_fetch_error", 32'(fetch_error), 32'(m_err));
            if (m_err) chk("m_err_no_req", 32'(imem_req), 32'd0);
            if (m_pend) begin
                m_pc   = taken(m_runc, m_rcond, zero_flag) ? (m_rimm ? m_raddr : m_pc + m_raddr)
                                                           : m_pc + 1'b1;
                m_pend = 1'b0;
            end else if (redirect_valid && redirect_ready) begin
                m_pend = 1'b1; m_runc = redirect_uncond; m_rimm = redirect_imm_sel;
                m_rcond = redirect_cond; m_raddr = redirect_addr; m_wait = 0;
            end else if (imem_req && imem_ack) begin
                m_ipc = m_pc; m_pc = m_pc + 1'b1; m_wait = 0;
            end else if (imem_req) begin
                m_wait++;
`ifdef FETCH_TIMEOUT_EN
                if (m_wait == int'(TO)) m_err = 1'b1;
`endif
            end
        end
    end

    initial begin
        rst_n = 1'b0; halt = 1'b0; instr_ready = 1'b1; redirect_valid = 1'b0;
        redirect_imm_sel = 1'b0; redirect_uncond = 1'b0; redirect_cond = 3'd0;
        redirect_addr = '0; zero_flag = 1'b0; ack_en = 1'b1; ack_wait = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'd0);
        chk("rst_pc_enable", 32'(pc_enable), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_redirect_ready", 32'(redirect_ready), 32'd0);
        chk("rst_fetch_error", 32'(fetch_error), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_instr_pc", 32'(instr_pc), 32'd0);
        chk("rst_jbs", 32'(jump_branch_select), 32'd0);
        chk("rst_addr_imm", 32'(address_immediate), 32'd0);
        @(posedge clk); #1;
        for (int c = 0; c <= 60; c++) begin
            cyc = c;
            case (c)
                0:  rst_n = 1'b1;
                10: ack_wait = 3;
                15: begin ack_wait = 0; instr_ready = 1'b0; end
                19: instr_ready = 1'b1;
                21: begin instr_ready = 1'b0; redirect_valid = 1'b1; redirect_uncond = 1'b1;
                          redirect_imm_sel = 1'b1; redirect_addr = 12'h123; end
                22: begin redirect_valid = 1'b0; instr_ready = 1'b1; end
                24: begin redirect_valid = 1'b1; redirect_addr = 12'h010; end
                25: redirect_valid = 1'b0;
                26: begin redirect_valid = 1'b1; redirect_uncond = 1'b0; redirect_cond = 3'd1;
                          redirect_addr = 12'h3AB; end
                27: redirect_valid = 1'b0;
                29: halt = 1'b1;
                30: begin redirect_valid = 1'b1; redirect_uncond = 1'b1; redirect_cond = 3'd0;
                          redirect_addr = 12'h777; end
                32: begin halt = 1'b0; redirect_valid = 1'b0; end
                35: ack_en = 1'b0;
                56: begin rst_n = 1'b0; ack_en = 1'b1; end
                57: rst_n = 1'b1;
                default: ;
            endcase
            @(negedge clk);
            case (c)
                0:  chk("c0_idle_no_req", 32'(imem_req), 32'd0);
                1:  begin chk("c1_req", 32'(imem_req), 32'd1); chk("c1_addr", 32'(imem_addr), 32'h000);
                          chk("c1_pc_enable", 32'(pc_enable), 32'd1); end
                2:  begin chk("c2_valid", 32'(instr_valid), 32'd1); chk("c2_instr_pc", 32'(instr_pc), 32'h000);
                          chk("c2_instr", 32'(instr), 32'hA000); end
                3:  chk("c3_addr", 32'(imem_addr), 32'h001);
                4:  chk("c4_instr_pc", 32'(instr_pc), 32'h001);
                5:  begin chk("c5_req", 32'(imem_req), 32'd1); chk("c5_addr", 32'(imem_addr), 32'h002); end
                11, 12, 13: begin chk("wait_req", 32'(imem_req), 32'd1);
                          chk("wait_addr", 32'(imem_addr), 32'h005); chk("wait_pc_enable", 32'(pc_enable), 32'd0); end
                14: begin chk("ack_addr", 32'(imem_addr), 32'h005); chk("ack_pc_enable", 32'(pc_enable), 32'd1); end
                15, 16, 17, 18: begin chk("stall_valid", 32'(instr_valid), 32'd1);
                          chk("stall_instr", 32'(instr), 32'hA005); chk("stall_instr_pc", 32'(instr_pc), 32'h005);
                          chk("stall_no_req", 32'(imem_req), 32'd0); chk("stall_pc", 32'(pc), 32'h006); end
                20: chk("c20_addr", 32'(imem_addr), 32'h006);
                21: chk("hold_redir_pc_enable", 32'(pc_enable), 32'd0);
                22: begin chk("redir_jbs", 32'(jump_branch_select), 32'd1);
                          chk("redir_addr_imm", 32'(address_immediate), 32'h123);
                          chk("redir_uncond", 32'(unconditional_branch), 32'd1);
                          chk("redir_imm", 32'(immediate_select), 32'd1);
                          chk("redir_pc_enable", 32'(pc_enable), 32'd1);
                          chk("redir_drop_valid", 32'(instr_valid), 32'd0); end
                23: chk("c23_addr", 32'(imem_addr), 32'h123);
                26: begin chk("c26_addr", 32'(imem_addr), 32'h010); chk("c26_pc_enable", 32'(pc_enable), 32'd0); end
                27: begin chk("c27_jbs", 32'(jump_branch_select), 32'd1); chk("c27_cond", 32'(branch_condition), 32'd1);
                          chk("c27_uncond", 32'(unconditional_branch), 32'd0);
                          chk("c27_addr_imm", 32'(address_immediate), 32'h3AB); end
                28: chk("c28_addr", 32'(imem_addr), 32'h011);
                29: begin chk("c29_instr_pc", 32'(instr_pc), 32'h011); chk("c29_instr", 32'(instr), 32'hA011); end
                30, 31, 32: begin chk("halt_no_req", 32'(imem_req), 32'd0);
                          chk("halt_no_ready", 32'(redirect_ready), 32'd0); end
                33: begin chk("c33_req", 32'(imem_req), 32'd1); chk("c33_addr", 32'(imem_addr), 32'h012); end
`ifdef FETCH_TIMEOUT_EN
                49: begin chk("c49_req", 32'(imem_req), 32'd1); chk("c49_err", 32'(fetch_error), 32'd0); end
                50, 55: begin chk("to_no_req", 32'(imem_req), 32'd0); chk("to_err", 32'(fetch_error), 32'd1); end
`else
                50, 55: begin chk("wait_forever_req", 32'(imem_req), 32'd1);
                          chk("wait_forever_addr", 32'(imem_addr), 32'h013);
                          chk("no_err", 32'(fetch_error), 32'd0); end
`endif
                56: begin chk("mid_rst_req", 32'(imem_req), 32'd0); chk("mid_rst_err", 32'(fetch_error), 32'd0);
                          chk("mid_rst_instr", 32'(instr), 32'd0); chk("mid_rst_instr_pc", 32'(instr_pc), 32'd0);
                          chk("mid_rst_valid", 32'(instr_valid), 32'd0); end
                57: chk("c57_idle", 32'(imem_req), 32'd0);
                58: begin chk("c58_req", 32'(imem_req), 32'd1); chk("c58_addr", 32'(imem_addr), 32'h000); end
                default: ;
            endcase
            @(posedge clk); #1;
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
